// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer states, entry kinds, handler vectors
// and the opcode fields the control decoder uses to recognise eret.
package cpu_pkg;

  typedef enum logic [1:0] {
    USER      = 2'd0,
    WAIT_SAFE = 2'd1,
    ENTER     = 2'd2,
    KERNEL    = 2'd3
  } state_e;

  typedef enum logic {
    KIND_IRQ = 1'b0,
    KIND_EXC = 1'b1
  } kind_e;

  localparam logic [2:0]  CAUSE_EXC  = 3'd7;

  localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0008;

  // eret is a COP0-format instruction identified by opcode plus funct
  localparam logic [5:0]  OPCODE_COP0 = 6'b010000;
  localparam logic [5:0]  FUNCT_ERET  = 6'b011000;

  // Return address after an exception skips the faulting instruction;
  // the add wraps naturally at 32 bits.
  function automatic logic [31:0] exc_return_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for signals arriving asynchronously to clk.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First flop may go metastable; the second gives it a cycle to settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/irq_exc_sequencer.sv
// Interrupt/exception entry and eret exit sequencer for the 5-stage pipeline.
// Interrupts wait for an ID slot free of branches, jumps and stalls;
// exceptions enter immediately. EPC, cause and kernel mode are held until eret.
module irq_exc_sequencer
  import cpu_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] IRQ_VECTOR = cpu_pkg::IRQ_VECTOR,
  parameter logic [31:0] EXC_VECTOR = cpu_pkg::EXC_VECTOR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_req,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               exc_id,
  input  logic               eret_id,
  input  logic [31:0]        pc_id,
  input  logic               branch_id,
  input  logic               jump_id,
  input  logic               stall_id,
  output logic               intterupt,
  output logic               exception,
  output logic               flush_if,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic [31:0]        epc,
  output logic [2:0]         cause,
  output logic               kernel_mode,
  output logic               nest_err
);

  logic [NUM_SRC-1:0] irq_s;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] req_vec;
  logic [2:0]         first_idx;
  logic               safe_slot;
  logic               eret_return;

  state_e             state_q;
  kind_e              kind_q;
  logic [31:0]        epc_q;
  logic [2:0]         cause_q;
  logic               nest_err_q;

  sync2 #(.WIDTH(NUM_SRC)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (irq_req),
    .q_o   (irq_s)
  );

  // Enable register: software may rewrite it in any state; the new mask
  // is seen by the pending check from the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= '0;
    end else if (mask_we) begin
      enable_q <= mask_wdata;
    end
  end

  assign req_vec   = irq_s & enable_q;
  assign safe_slot = !branch_id && !jump_id && !stall_id;

  // Lowest-index pending source wins; scanning downwards lets the last hit stick.
  always_comb begin
    first_idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        first_idx = i[2:0];
      end
    end
  end

  // Sequencer FSM; EPC and cause are captured on the cycle that moves into
  // ENTER so a mask write during ENTER cannot disturb them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= USER;
      kind_q     <= KIND_IRQ;
      epc_q      <= '0;
      cause_q    <= '0;
      nest_err_q <= 1'b0;
    end else begin
      case (state_q)
        USER: begin
          if (exc_id) begin
            state_q <= ENTER;
            kind_q  <= KIND_EXC;
            epc_q   <= exc_return_pc(pc_id);
            cause_q <= CAUSE_EXC;
          end else if (|req_vec) begin
            state_q <= WAIT_SAFE;
          end
        end
        WAIT_SAFE: begin
          if (exc_id) begin
            state_q <= ENTER;
            kind_q  <= KIND_EXC;
            epc_q   <= exc_return_pc(pc_id);
            cause_q <= CAUSE_EXC;
          end else if (req_vec == '0) begin
            state_q <= USER;
          end else if (safe_slot) begin
            state_q <= ENTER;
            kind_q  <= KIND_IRQ;
            epc_q   <= pc_id;
            cause_q <= first_idx;
          end
        end
        ENTER: begin
          state_q <= KERNEL;
        end
        KERNEL: begin
          if (exc_id) begin
            nest_err_q <= 1'b1;
          end
          if (eret_id) begin
            state_q <= USER;
          end
        end
        default: begin
          state_q <= USER;
        end
      endcase
    end
  end

  assign eret_return = (state_q == KERNEL) && eret_id;

  // Redirect/flush/strobe outputs decoded from state and the registered kind.
  always_comb begin
    intterupt   = 1'b0;
    exception   = 1'b0;
    flush_if    = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = 32'd0;
    if (state_q == ENTER) begin
      flush_if    = 1'b1;
      pc_redirect = 1'b1;
      if (kind_q == KIND_EXC) begin
        exception = 1'b1;
        pc_target = EXC_VECTOR;
      end else begin
        intterupt = 1'b1;
        pc_target = IRQ_VECTOR;
      end
    end else if (eret_return) begin
      flush_if    = 1'b1;
      pc_redirect = 1'b1;
      pc_target   = epc_q;
    end
  end

  assign epc         = epc_q;
  assign cause       = cause_q;
  assign nest_err    = nest_err_q;
  assign kernel_mode = (state_q == KERNEL);

endmodule

// File: tb/tb_irq_exc_sequencer.sv
// Directed bench for irq_exc_sequencer: a per-cycle vector table for the
// interrupt paths plus hand sequences for exceptions, nesting and async reset.
module tb_irq_exc_sequencer;

  localparam logic [31:0] IV = 32'h8000_0004;
  localparam logic [31:0] EV = 32'h8000_0008;
  localparam logic [31:0] P0 = 32'h0040_0020;
  localparam logic [31:0] P1 = 32'h0040_1000;
  localparam logic [31:0] P2 = 32'h0040_1010;
  localparam logic [31:0] P3 = 32'h0040_2000;

  typedef struct packed {
    logic        intr;
    logic        exc;
    logic        flush;
    logic        redir;
    logic [31:0] target;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        kern;
    logic        nest;
  } out_t;

  typedef struct {
    string       name;
    logic [3:0]  irq;
    logic        mwe;
    logic [3:0]  mdata;
    logic        exc;
    logic        eret;
    logic [31:0] pc;
    logic        br;
    logic        jp;
    logic        st;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_req;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic        exc_id;
  logic        eret_id;
  logic [31:0] pc_id;
  logic        branch_id;
  logic        jump_id;
  logic        stall_id;
  logic        intterupt;
  logic        exception;
  logic        flush_if;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic [31:0] epc;
  logic [2:0]  cause;
  logic        kernel_mode;
  logic        nest_err;

  int testsRun;
  int testsFailed;
  vec_t vecs[24];

  irq_exc_sequencer #(.NUM_SRC(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_req     (irq_req),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .exc_id      (exc_id),
    .eret_id     (eret_id),
    .pc_id       (pc_id),
    .branch_id   (branch_id),
    .jump_id     (jump_id),
    .stall_id    (stall_id),
    .intterupt   (intterupt),
    .exception   (exception),
    .flush_if    (flush_if),
    .pc_redirect (pc_redirect),
    .pc_target   (pc_target),
    .epc         (epc),
    .cause       (cause),
    .kernel_mode (kernel_mode),
    .nest_err    (nest_err)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic out_t mkOut(logic i, logic e, logic f, logic r, logic [31:0] tgt,
                                 logic [31:0] ep, logic [2:0] c, logic k, logic n);
    out_t o;
    o = '{intr: i, exc: e, flush: f, redir: r, target: tgt, epc: ep, cause: c, kern: k, nest: n};
    return o;
  endfunction

  function automatic out_t idle(logic [31:0] ep, logic [2:0] c, logic k, logic n);
    return mkOut(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, ep, c, k, n);
  endfunction

  function automatic vec_t mkVec(string nm, logic [3:0] irq, logic mwe, logic [3:0] md,
                                 logic exc, logic eret, logic [31:0] pc,
                                 logic br, logic jp, logic st, out_t ex);
    vec_t v;
    v.name = nm; v.irq = irq; v.mwe = mwe; v.mdata = md; v.exc = exc; v.eret = eret;
    v.pc = pc; v.br = br; v.jp = jp; v.st = st; v.exp = ex;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    irq_req    = v.irq;
    mask_we    = v.mwe;
    mask_wdata = v.mdata;
    exc_id     = v.exc;
    eret_id    = v.eret;
    pc_id      = v.pc;
    branch_id  = v.br;
    jump_id    = v.jp;
    stall_id   = v.st;
  endtask

  task automatic checkOutput(input string nm, input out_t ex);
    out_t act;
    act = {intterupt, exception, flush_if, pc_redirect, pc_target, epc, cause, kernel_mode, nest_err};
    testsRun++;
    if (act !== ex) begin
      testsFailed++;
      $display("[TB] FAIL %s: got int=%b exc=%b flush=%b redir=%b tgt=%h epc=%h cause=%0d kern=%b nest=%b, want int=%b exc=%b flush=%b redir=%b tgt=%h epc=%h cause=%0d kern=%b nest=%b",
               nm, act.intr, act.exc, act.flush, act.redir, act.target, act.epc, act.cause, act.kern, act.nest,
               ex.intr, ex.exc, ex.flush, ex.redir, ex.target, ex.epc, ex.cause, ex.kern, ex.nest);
    end
  endtask

  // Drive one cycle's inputs, check the settled outputs, then clock once.
  task automatic runVec(input vec_t v);
    applyStimulus(v);
    #1;
    checkOutput(v.name, v.exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    // Basic entry (raise at vec1, first sampling edge t), withdrawal after
    // eret, then a safe-slot wait with a mask write during ENTER.
    vecs[0]  = mkVec("en_write",    4'h0, 1, 4'hF, 0, 0, P0, 0, 0, 0, idle(0, 0, 0, 0));
    vecs[1]  = mkVec("irq_t",       4'h2, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(0, 0, 0, 0));
    vecs[2]  = mkVec("irq_t1",      4'h2, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(0, 0, 0, 0));
    vecs[3]  = mkVec("irq_t2",      4'h2, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(0, 0, 0, 0));
    vecs[4]  = mkVec("irq_t3_wait", 4'h2, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(0, 0, 0, 0));
    vecs[5]  = mkVec("irq_enter",   4'h2, 0, 4'h0, 0, 0, P0, 0, 0, 0, mkOut(1, 0, 1, 1, IV, P0, 1, 0, 0));
    vecs[6]  = mkVec("irq_kernel",  4'h2, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(P0, 1, 1, 0));
    vecs[7]  = mkVec("irq_eret",    4'h0, 0, 4'h0, 0, 1, P0, 0, 0, 0, mkOut(0, 0, 1, 1, P0, P0, 1, 1, 0));
    vecs[8]  = mkVec("post_eret",   4'h0, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(P0, 1, 0, 0));
    vecs[9]  = mkVec("withdrawn",   4'h0, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(P0, 1, 0, 0));
    vecs[10] = mkVec("user_idle",   4'h0, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(P0, 1, 0, 0));
    vecs[11] = mkVec("ss_raise",    4'h1, 0, 4'h0, 0, 0, P1, 1, 0, 0, idle(P0, 1, 0, 0));
    vecs[12] = mkVec("ss_sync",     4'h1, 0, 4'h0, 0, 0, P1, 1, 0, 0, idle(P0, 1, 0, 0));
    vecs[13] = mkVec("ss_pending",  4'h1, 0, 4'h0, 0, 0, P1, 1, 0, 0, idle(P0, 1, 0, 0));
    vecs[14] = mkVec("ss_branch1",  4'h1, 0, 4'h0, 0, 0, P1, 1, 0, 0, idle(P0, 1, 0, 0));
    vecs[15] = mkVec("ss_branch2",  4'h1, 0, 4'h0, 0, 0, P1, 1, 0, 0, idle(P0, 1, 0, 0));
    vecs[16] = mkVec("ss_branch3",  4'h1, 0, 4'h0, 0, 0, P1, 1, 0, 0, idle(P0, 1, 0, 0));
    vecs[17] = mkVec("ss_stall",    4'h1, 0, 4'h0, 0, 0, P1, 0, 0, 1, idle(P0, 1, 0, 0));
    vecs[18] = mkVec("ss_safe",     4'h1, 0, 4'h0, 0, 0, P2, 0, 0, 0, idle(P0, 1, 0, 0));
    vecs[19] = mkVec("ss_enter_mw", 4'h1, 1, 4'h0, 0, 0, P2, 0, 0, 0, mkOut(1, 0, 1, 1, IV, P2, 0, 0, 0));
    vecs[20] = mkVec("ss_kernel",   4'h1, 0, 4'h0, 0, 0, P2, 0, 1, 0, idle(P2, 0, 1, 0));
    vecs[21] = mkVec("ss_eret",     4'h1, 0, 4'h0, 0, 1, P2, 0, 0, 0, mkOut(0, 0, 1, 1, P2, P2, 0, 1, 0));
    vecs[22] = mkVec("masked_usr1", 4'h1, 0, 4'h0, 0, 0, P2, 0, 0, 0, idle(P2, 0, 0, 0));
    vecs[23] = mkVec("masked_usr2", 4'h1, 0, 4'h0, 0, 0, P2, 0, 0, 0, idle(P2, 0, 0, 0));

    applyStimulus(mkVec("init", 4'h0, 0, 4'h0, 0, 0, 32'd0, 0, 0, 0, idle(0, 0, 0, 0)));
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_values", idle(0, 0, 0, 0));
    reset = 1'b0;

    // Masked request must never be taken while the enable register is zero.
    for (int i = 0; i < 20; i++) begin
      runVec(mkVec($sformatf("masked_%0d", i), 4'h2, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(0, 0, 0, 0)));
    end
    for (int i = 0; i < 3; i++) begin
      runVec(mkVec($sformatf("drain_%0d", i), 4'h0, 0, 4'h0, 0, 0, P0, 0, 0, 0, idle(0, 0, 0, 0)));
    end

    for (int i = 0; i < 24; i++) begin
      runVec(vecs[i]);
    end

    // Exception beats a pending irq[0] and a coincident stall; EPC wraps.
    runVec(mkVec("ex_enable",   4'h1, 1, 4'hF, 0, 0, P2, 1, 0, 0, idle(P2, 0, 0, 0)));
    runVec(mkVec("ex_pending",  4'h1, 0, 4'h0, 0, 0, P2, 1, 0, 0, idle(P2, 0, 0, 0)));
    runVec(mkVec("ex_raise",    4'h1, 0, 4'h0, 1, 0, 32'hFFFF_FFFC, 1, 0, 1, idle(P2, 0, 0, 0)));
    runVec(mkVec("ex_enter",    4'h4, 0, 4'h0, 0, 0, P3, 0, 0, 0, mkOut(0, 1, 1, 1, EV, 32'd0, 7, 0, 0)));
    // Nested exception in KERNEL only sets the sticky error.
    runVec(mkVec("nest_raise",  4'h4, 0, 4'h0, 1, 0, P3, 0, 0, 0, idle(32'd0, 7, 1, 0)));
    runVec(mkVec("nest_sticky", 4'h4, 0, 4'h0, 0, 0, P3, 0, 0, 0, idle(32'd0, 7, 1, 1)));
    // Return with irq[2] still pending, then re-entry through WAIT_SAFE.
    runVec(mkVec("ret_eret",    4'h4, 0, 4'h0, 0, 1, P3, 0, 0, 0, mkOut(0, 0, 1, 1, 32'd0, 32'd0, 7, 1, 1)));
    runVec(mkVec("ret_user",    4'h4, 0, 4'h0, 0, 0, P3, 0, 0, 0, idle(32'd0, 7, 0, 1)));
    runVec(mkVec("ret_wait",    4'h4, 0, 4'h0, 0, 0, P3, 0, 0, 0, idle(32'd0, 7, 0, 1)));
    runVec(mkVec("reenter",     4'h4, 0, 4'h0, 0, 0, P3, 0, 0, 0, mkOut(1, 0, 1, 1, IV, P3, 2, 0, 1)));
    runVec(mkVec("re_kernel",   4'h4, 0, 4'h0, 0, 0, P3, 0, 0, 0, idle(P3, 2, 1, 1)));

    // Asynchronous reset between clock edges while in KERNEL.
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset", idle(0, 0, 0, 0));
    #1;
    reset = 1'b0;

    // Exception and eret together in KERNEL: eret wins, nest_err still set.
    runVec(mkVec("sim_raise",   4'h0, 0, 4'h0, 1, 0, 32'h0000_0100, 0, 0, 0, idle(0, 0, 0, 0)));
    runVec(mkVec("sim_enter",   4'h0, 0, 4'h0, 0, 0, 32'h0000_0100, 0, 0, 0, mkOut(0, 1, 1, 1, EV, 32'h104, 7, 0, 0)));
    runVec(mkVec("sim_both",    4'h0, 0, 4'h0, 1, 1, 32'h0000_0100, 0, 0, 0, mkOut(0, 0, 1, 1, 32'h104, 32'h104, 7, 1, 0)));
    runVec(mkVec("sim_after",   4'h0, 0, 4'h0, 0, 0, 32'h0000_0100, 0, 0, 0, idle(32'h104, 7, 0, 1)));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/irq_exc_sequencer.md
Name: irq_exc_sequencer

Overview:
- Sequences interrupt and exception entry and exit for the 5-stage pipeline.
- Synchronises and masks external interrupt requests, then waits for a safe slot in ID (no branch, jump or stall).
- Drives one-cycle `intterupt`/`exception` strobes into the ID-stage control decoder, flushes IF and redirects the PC to the handler.
- Holds EPC and kernel mode until `eret` is decoded.

Parameters:
- NUM_SRC, 4, number of external interrupt sources (1..8).
- IRQ_VECTOR, 32'h8000_0004, handler PC for interrupts.
- EXC_VECTOR, 32'h8000_0008, handler PC for exceptions (undefined instruction).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_req  in  NUM_SRC  level interrupt requests from peripherals, asynchronous to clk.
- mask_we  in  1  write strobe for the enable register.
- mask_wdata  in  NUM_SRC  new enable-register value.
- exc_id  in  1  undefined-opcode detected in ID.
- eret_id  in  1  `eret` decoded in ID.
- pc_id  in  32  PC of the instruction in ID.
- branch_id  in  1  branch in ID.
- jump_id  in  1  j/jal/jr/jalr in ID.
- stall_id  in  1  load-use stall this cycle.
- intterupt  out  1  to control decoder; one-cycle strobe.
- exception  out  1  to control decoder; one-cycle strobe.
- flush_if  out  1  squash IF/ID register.
- pc_redirect  out  1  PC mux selects pc_target.
- pc_target  out  32  redirect address.
- epc  out  32  saved return PC.
- cause  out  3  index of the serviced source; 3'd7 = exception.
- kernel_mode  out  1  handler active, interrupts masked.
- nest_err  out  1  sticky: exception raised while in kernel mode.

Behaviour:
- **Reset values:** all outputs 0 except cause = 0. Enable register = 0 (all masked). FSM = USER. Synchroniser flops = 0. Reset mid-handler returns to USER and drops kernel_mode immediately.
- **Synchroniser:** irq_req passes through 2 flops, giving irq_s. Request vector = irq_s & enable.
  - Latency from an irq_req edge to a visible pending bit is 2 clk.
- **Enable register:** loads mask_wdata on mask_we in any state. A newly written value affects the pending check next cycle.
- **FSM states:** USER, WAIT_SAFE, ENTER, KERNEL.
- **USER:**
  - exc_id = 1 → ENTER with kind = EXC. Exceptions do not wait for a safe slot and take priority over a pending interrupt in the same cycle.
  - Else if the request vector is nonzero → WAIT_SAFE.
- **WAIT_SAFE:**
  - exc_id = 1 → ENTER (EXC).
  - Else if the request vector becomes 0 (request withdrawn) → USER.
  - Else if !branch_id && !jump_id && !stall_id → ENTER (IRQ).
  - Else remain. No timeout.
- **ENTER (exactly 1 cycle):**
  - Asserts flush_if = 1 and pc_redirect = 1.
  - IRQ kind: intterupt = 1, pc_target = IRQ_VECTOR, epc ← pc_id (the interrupted instruction re-executes), cause ← lowest-index set bit of the request vector sampled on the transition cycle.
  - EXC kind: exception = 1, pc_target = EXC_VECTOR, epc ← pc_id + 4 (32-bit wrap, faulting instruction skipped), cause ← 7.
  - Next state: KERNEL.
- **KERNEL:**
  - kernel_mode = 1; interrupts ignored (they stay pending).
  - exc_id sets nest_err (sticky until reset); there is no re-entry and epc is unchanged.
  - eret_id → USER with pc_redirect = 1, pc_target = epc and flush_if = 1 in that same cycle; kernel_mode drops next cycle.
  - After returning, a still-pending enabled request re-enters via WAIT_SAFE no earlier than 1 cycle later.
- **Decoder coupling:** intterupt/exception are high only in ENTER. A stall_id coincident with an exception entry still forces exception, because the decoder gives intterupt/exception precedence over stall.
- **Registered/combinational split:** epc, cause and nest_err are registered. flush_if, pc_redirect, pc_target, intterupt and exception are combinational from state plus registered kind.
- **Simultaneous events:** exc_id and eret_id both high in KERNEL → eret wins and nest_err is set. mask_we in ENTER does not alter the cause already captured.

Decomposition:
- Shared package `cpu_pkg` holds:
  - state enum {USER, WAIT_SAFE, ENTER, KERNEL};
  - localparam CAUSE_EXC = 3'd7;
  - vector constants IRQ_VECTOR/EXC_VECTOR;
  - opcode constants shared with the control decoder (ERET funct/opcode).
- One sub-module: `sync2`, a parameterised-width 2-flop synchroniser with async reset, instantiated once for irq_req.
- The priority encoder stays inline.

Test Plan:
- **Reset and masked request:** reset, then irq_req = 4'b0010 with enable = 0 for 20 cycles → intterupt never 1; state stays USER; epc = 0.
- **Basic interrupt entry:** write enable = 4'b1111, raise irq_req[1] at cycle t; pc_id = 32'h0040_0020 with no branch/jump/stall → intterupt pulses at t+3 for exactly 1 cycle; pc_target = 32'h8000_0004; epc = 32'h0040_0020; cause = 1; kernel_mode = 1 from t+4.
- **Safe-slot wait:** irq pending while branch_id = 1 for 3 cycles and then stall_id = 1 for 1 cycle → no entry until the first cycle with all three low; epc = pc_id of that cycle.
- **Exception priority:** exc_id = 1 and irq_req[0] pending in the same cycle with pc_id = 32'hFFFF_FFFC → exception = 1, intterupt = 0, cause = 7, epc = 32'h0000_0000 (wrap-around).
- **Return and re-entry:** in KERNEL, eret_id = 1 with irq_req[2] still high → pc_redirect = 1 and pc_target = epc that cycle; USER the next cycle; a new entry with cause = 2 follows no earlier than 1 cycle after that.
- **Nesting and async reset:** exc_id = 1 while in KERNEL → nest_err = 1, epc unchanged. Assert reset between clock edges mid-KERNEL → all outputs clear immediately, without waiting for a clk edge.
